mdio_master: RTL and testbench
==============================

# mdio_master

FPGA-side Clause-22 MDIO management master. It accepts single register read/write requests from the board register file, serialises them onto MDC/MDIO, and returns read data. It sits directly upstream of the virtual PHY and of the external Ethernet PHYs, and drives the same mdc / mdio_o / mdio_t / mdio_i tri-state bundle that the PS MAC otherwise provides.

## Interface
Parameters:
- CLK_DIV, 10, sysclk cycles per MDC half-period; minimum 2. The default gives about 2.46 MHz MDC at 49.152 MHz.
- PREAMBLE_LEN, 32, number of preamble 1-bits; range 1..32.

Ports:
- sysclk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled in IDLE only.
- req_rd  in  1  1 = read (OP 10), 0 = write (OP 01).
- phy_addr  in  5  PHYAD field.
- reg_addr  in  5  REGAD field.
- wr_data  in  16  write data.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rd_data  out  16  read data; held until the next read completes.
- ta_err  out  1  set if the read TA second bit sampled 1 (no PHY answered); held.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output data.
- mdio_t  out  1  tri-state control; 1 = released (input).
- mdio_i  in  1  MDIO input data.
- reg_raddr  in  16  debug read address.
- reg_rdata  out  32  debug read data.

## Operation
- States: IDLE → PRE → FRAME → TA → DATA → DONE → IDLE.
- IDLE:
  - mdc=0, mdio_t=1, mdio_o=1.
  - req=1 latches req_rd, phy_addr, reg_addr and wr_data, then moves to PRE.
- PRE: mdio_t=0, mdio_o=1 for PREAMBLE_LEN bits.
- FRAME: 14 bits MSB-first: ST=01, OP, PHYAD, REGAD.
- TA:
  - Write drives 1 then 0.
  - Read sets mdio_t=1 for both bits. The second TA bit is sampled into ta_err.
- DATA:
  - Write drives wr_data[15:0] MSB-first.
  - Read keeps mdio_t=1 and shifts mdio_i into the shift register MSB-first.
- DONE: for reads, rd_data and ta_err update. done=1 and busy=0 in this same cycle. The next cycle is IDLE.
- Bit timing (this master is the only MDC source on the bus):
  - Every bit starts with mdc falling. mdio_o and mdio_t change on that same sysclk edge.
  - mdc rises CLK_DIV cycles later. Read bits are sampled on the sysclk edge that raises mdc.
- Frame shift register: 32 bits {ST, OP, PHYAD, REGAD, TA, DATA}. For reads, the TA and DATA positions hold the sampled mdio_i values.
- req while busy: ignored; no queueing.
- req_rd and the address/data inputs are don't-care outside the accept cycle.
- reset in any state:
  - Next cycle is IDLE with mdc=0, mdio_t=1, mdio_o=1, busy=0, done=0.
  - rd_data=0, ta_err=0.
  - The aborted transaction produces no done pulse.
- Reset values of outputs: mdc 0, mdio_o 1, mdio_t 1, busy 0, done 0, rd_data 0, ta_err 0, reg_rdata 0.

## Timing
- req accepted at edge N: busy=1 from N+1.
- Preamble bit 0 starts (mdc falls, already low) at N+1.
- Bits per frame: B = PREAMBLE_LEN+32. Each bit is 2·CLK_DIV cycles.
- done pulses at N+1+B·2·CLK_DIV. With defaults that is N+1281.
- mdc duty cycle is exactly 50%. mdc is low during DONE and IDLE.
- Back-to-back: a req held high in the done cycle is not accepted. The earliest accept is the cycle after done, so the next frame starts at done+2.
- rd_data and ta_err are valid in the done cycle.

## Configuration
- MDIO_MASTER_DEBUG_EN defined:
  - A 16-entry circular log stores the 32-bit frame shift register at every DONE, using a 4-bit write pointer that wraps.
  - reg_raddr[7:4]==4'hc returns log[reg_raddr[3:0]].
  - reg_raddr[7:0]==8'hbf returns {pointer[3:0], 12'd0, transaction count[15:0]}. The count wraps at 16 bits.
  - Log contents are not cleared by reset; pointer and count are.
- Undefined: no log storage; reg_rdata is constant 0. Ports remain present.

## Structure
- Shared package mdio_pkg holds:
  - State encoding.
  - MDIO_ST=2'b01, MDIO_OP_RD=2'b10, MDIO_OP_WR=2'b01.
  - MDIO_FRAME_BITS=32 and the default CLK_DIV.
- One sub-module, mdc_gen:
  - Divider producing mdc, a fall strobe and a rise strobe.
  - Enabled only while busy; forced low and reset on reset.
- Top level: FSM, bit counter (6 bits), shift register, optional debug log.

## Test plan
- Read PHY 1 reg 2 with a virtual-PHY model attached:
  - rd_data=16'h7e19, ta_err=0.
  - Log entry = 32'h6088_7e19.
  - done at req+1281 cycles.
- Read PHY 8 reg 0: rd_data=16'h0040.
- Write PHY 1 reg 0 data 16'h1234:
  - The mdio_o bit stream after the preamble equals 32'h5082_1234.
  - mdio_t=0 throughout; rd_data unchanged.
- No PHY present (mdio_i tied 1), read PHY 3 reg 1: ta_err=1, rd_data=16'hFFFF.
- Assert reset at bit 40 of a read:
  - Next cycle: mdc=0, mdio_t=1, busy=0.
  - No done pulse.
  - A new request then completes normally.
- req held high continuously:
  - Frames are separated by exactly 2 idle cycles.
  - A req pulse during busy produces no extra done.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO constants, FSM encoding and frame builder.
// Used by mdio_master and mdc_gen.
package mdio_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_FRAME = 3'd2;
  localparam logic [2:0] ST_TA    = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam int MDIO_FRAME_BITS = 32;
  localparam int MDIO_CLK_DIV    = 10;

  function automatic logic [31:0] mdio_frame(
    input logic        rd,
    input logic [4:0]  phy,
    input logic [4:0]  ra,
    input logic [15:0] data
  );
    return {MDIO_ST, rd ? MDIO_OP_RD : MDIO_OP_WR,
            phy, ra, 2'b10, data};
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Register-file request/response bundle of the MDIO master.
// master = requester side, slave = mdio_master side.
interface mdio_master_if;
  logic        req;
  logic        req_rd;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;
  logic        ta_err;

  modport master (
    output req, req_rd, phy_addr, reg_addr, wr_data,
    input  busy, done, rd_data, ta_err
  );

  modport slave (
    input  req, req_rd, phy_addr, reg_addr, wr_data,
    output busy, done, rd_data, ta_err
  );
endinterface

// File: rtl/mdc_gen.sv
// MDC divider: CLK_DIV sysclk cycles per half period, low when idle.
// rise_o/fall_o flag the sysclk edge on which mdc changes.
module mdc_gen
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = MDIO_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic          mdc_q;
  logic          last;

  assign last   = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = last && !mdc_q;
  assign fall_o = last && mdc_q;
  assign mdc_o  = mdc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (last) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: preamble, ST/OP/PHYAD/REGAD, TA, 16-bit data.
// Optional frame log behind MDIO_MASTER_DEBUG_EN.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = MDIO_CLK_DIV,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic         sysclk,
  input  logic         reset,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_t,
  input  logic         mdio_i,
  input  logic [15:0]  reg_raddr,
  output logic [31:0]  reg_rdata
);

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] sh_q, sh_d;
  logic        mdo_q, mdo_d;
  logic        mdt_q, mdt_d;
  logic        rd_q;
  logic [15:0] rdata_q;
  logic        taerr_q;
  logic        run, rise, fall, shifting, sin, fin;

  assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .en_i   (run),
    .mdc_o  (mdc),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Header bits rotate back into place; TA/DATA of a read take mdio_i.
  assign shifting = (state_q == ST_FRAME) || (state_q == ST_TA)
                 || (state_q == ST_DATA);
  assign sin = (rd_q && state_q != ST_FRAME) ? mdio_i : sh_q[31];

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    mdo_d   = mdo_q;
    mdt_d   = mdt_q;
    unique case (state_q)
      ST_IDLE: if (bus.req) begin
        state_d = ST_PRE;
        bit_d   = '0;
        sh_d    = mdio_frame(bus.req_rd, bus.phy_addr,
                             bus.reg_addr, bus.wr_data);
        mdt_d   = 1'b0;
        mdo_d   = 1'b1;
      end
      ST_PRE: if (fall) begin
        if (bit_q == PRE_LAST) begin
          state_d = ST_FRAME;
          bit_d   = '0;
        end else bit_d = bit_q + 6'd1;
      end
      ST_FRAME: if (fall) begin
        if (bit_q == 6'd13) begin
          state_d = ST_TA;
          bit_d   = '0;
        end else bit_d = bit_q + 6'd1;
      end
      ST_TA: if (fall) begin
        if (bit_q == 6'd1) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end else bit_d = bit_q + 6'd1;
      end
      ST_DATA: if (fall) begin
        if (bit_q == 6'd15) state_d = ST_DONE;
        else bit_d = bit_q + 6'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rise && shifting) sh_d = {sh_q[30:0], sin};
    if (fall) begin
      mdt_d = (state_d == ST_DONE) || (rd_q &&
              (state_d == ST_TA || state_d == ST_DATA));
      mdo_d = (state_d == ST_PRE || mdt_d) ? 1'b1 : sh_q[31];
    end
  end

  assign fin = (state_q == ST_DATA) && (state_d == ST_DONE);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      mdo_q   <= 1'b1;
      mdt_q   <= 1'b1;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      taerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      mdo_q   <= mdo_d;
      mdt_q   <= mdt_d;
      if (state_q == ST_IDLE && bus.req) rd_q <= bus.req_rd;
      if (fin && rd_q) begin
        rdata_q <= sh_q[15:0];
        taerr_q <= sh_q[16];
      end
    end
  end

  assign mdio_o      = mdo_q;
  assign mdio_t      = mdt_q;
  assign bus.busy    = run;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.rd_data = rdata_q;
  assign bus.ta_err  = taerr_q;

  logic unused_raddr;
  assign unused_raddr = ^reg_raddr;

`ifdef MDIO_MASTER_DEBUG_EN
  logic [31:0] log_q [16];
  logic [3:0]  ptr_q;
  logic [15:0] cnt_q;
  logic [31:0] dbg_q;

  // Log survives reset so a post-mortem read still shows history.
  always_ff @(posedge sysclk) begin
    if (!reset && state_q == ST_DONE) log_q[ptr_q] <= sh_q;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      dbg_q <= '0;
    end else begin
      if (state_q == ST_DONE) begin
        ptr_q <= ptr_q + 4'd1;
        cnt_q <= cnt_q + 16'd1;
      end
      if (reg_raddr[7:4] == 4'hc) dbg_q <= log_q[reg_raddr[3:0]];
      else if (reg_raddr[7:0] == 8'hbf) dbg_q <= {ptr_q, 12'd0, cnt_q};
      else dbg_q <= '0;
    end
  end

  assign reg_rdata = dbg_q;
`else
  assign reg_rdata = '0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master with a small Clause-22 PHY model.
// Define MDIO_MASTER_DEBUG_EN to also check the frame log.
module tb_mdio_master;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        mdc, mdio_o, mdio_t;
  logic        mdio_i = 1'b1;
  logic [15:0] reg_raddr = 16'h00c0;
  logic [31:0] reg_rdata;

  mdio_master_if bus();

  mdio_master dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .bus       (bus),
    .mdc       (mdc),
    .mdio_o    (mdio_o),
    .mdio_t    (mdio_t),
    .mdio_i    (mdio_i),
    .reg_raddr (reg_raddr),
    .reg_rdata (reg_rdata)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Virtual PHY register contents; PHYs 1 and 8 are present.
  function automatic logic [15:0] vphy_reg(input logic [4:0] pa,
                                           input logic [4:0] ra);
    case ({pa, ra})
      {5'd1, 5'd2}: return 16'h7e19;
      {5'd1, 5'd0}: return 16'h1140;
      {5'd8, 5'd0}: return 16'h0040;
      default:      return 16'h0000;
    endcase
  endfunction

  // PHY model / monitor, sampled on the falling sysclk edge.
  int          mon_r = 0;
  int          t_high = 0;
  logic        mdc_prev = 1'b0;
  logic        drv = 1'b0;
  logic [13:0] hdr = '0;
  logic [31:0] wstream = '0;
  logic [15:0] resp = '0;

  always @(negedge sysclk) begin
    if (bus.busy && mdio_t) t_high++;
    if (reset || !bus.busy) begin
      mon_r  = 0;
      drv    = 1'b0;
      mdio_i = 1'b1;
    end else begin
      if (mdc && !mdc_prev) begin
        if (mon_r >= 32 && mon_r < 46) hdr = {hdr[12:0], mdio_o};
        if (mon_r >= 32 && mon_r < 64) wstream = {wstream[30:0], mdio_o};
        mon_r++;
      end
      if (!mdc && mdc_prev) begin
        if (mon_r == 46) begin
          drv  = (hdr[13:12] == 2'b01) && (hdr[11:10] == 2'b10)
              && (hdr[9:5] == 5'd1 || hdr[9:5] == 5'd8);
          resp = vphy_reg(hdr[9:5], hdr[4:0]);
        end
        if (drv && mon_r >= 46 && mon_r < 48) mdio_i = 1'b0;
        else if (drv && mon_r >= 48 && mon_r < 64) mdio_i = resp[63 - mon_r];
        else mdio_i = 1'b1;
      end
    end
    mdc_prev = mdc;
  end

  // Called at a falling edge in IDLE; returns in the cycle after done.
  task automatic run_txn(input logic rd, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd,
                         output int lat);
    int c;
    bus.req = 1'b1; bus.req_rd = rd;
    bus.phy_addr = pa; bus.reg_addr = ra; bus.wr_data = wd;
    @(negedge sysclk);
    bus.req = 1'b0; bus.req_rd = ~rd;
    bus.phy_addr = 5'($urandom); bus.reg_addr = 5'($urandom);
    bus.wr_data = 16'($urandom);
    c = 1;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    while (!bus.done && c < 3000) begin
      @(negedge sysclk);
      c++;
    end
    lat = c;
    check("busy_in_done", 32'(bus.busy), 32'd0);
    check("mdc_in_done", 32'(mdc), 32'd0);
    @(negedge sysclk);
  endtask

  initial begin
    int lat, th, nd, gap, t, guard;
    int dt[3];
    bit seen;

    bus.req = 1'b0; bus.req_rd = 1'b0;
    bus.phy_addr = '0; bus.reg_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    check("rst_mdc", 32'(mdc), 32'd0);
    check("rst_mdio_o", 32'(mdio_o), 32'd1);
    check("rst_mdio_t", 32'(mdio_t), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_ta_err", 32'(bus.ta_err), 32'd0);
    check("rst_reg_rdata", reg_rdata, 32'd0);

    run_txn(1'b1, 5'd1, 5'd2, 16'h0, lat);
    check("rd1_latency", lat, 32'd1281);
    check("rd1_data", 32'(bus.rd_data), 32'h7e19);
    check("rd1_ta_err", 32'(bus.ta_err), 32'd0);
    reg_raddr = 16'h00c0;
    repeat (2) @(negedge sysclk);
`ifdef MDIO_MASTER_DEBUG_EN
    check("log0", reg_rdata, 32'h6088_7e19);
    reg_raddr = 16'h00bf;
    repeat (2) @(negedge sysclk);
    check("log_ptr_cnt", reg_rdata, {4'd1, 12'd0, 16'd1});
`else
    check("reg_rdata_off", reg_rdata, 32'd0);
`endif

    run_txn(1'b1, 5'd8, 5'd0, 16'h0, lat);
    check("rd8_latency", lat, 32'd1281);
    check("rd8_data", 32'(bus.rd_data), 32'h0040);

    th = t_high;
    run_txn(1'b0, 5'd1, 5'd0, 16'h1234, lat);
    check("wr_latency", lat, 32'd1281);
    check("wr_stream", wstream, 32'h5082_1234);
    check("wr_mdio_t_low", t_high - th, 32'd0);
    check("wr_rd_data_held", 32'(bus.rd_data), 32'h0040);

    run_txn(1'b1, 5'd3, 5'd1, 16'h0, lat);
    check("nophy_ta_err", 32'(bus.ta_err), 32'd1);
    check("nophy_data", 32'(bus.rd_data), 32'hffff);

    // Abort a read in the middle of bit 40.
    bus.req = 1'b1; bus.req_rd = 1'b1;
    bus.phy_addr = 5'd1; bus.reg_addr = 5'd2;
    @(negedge sysclk);
    bus.req = 1'b0;
    guard = 0;
    while (mon_r < 40 && guard < 2000) begin
      @(negedge sysclk);
      guard++;
    end
    check("reach_bit40", 32'(mon_r >= 40), 32'd1);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    check("abort_mdc", 32'(mdc), 32'd0);
    check("abort_mdio_t", 32'(mdio_t), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rd_data", 32'(bus.rd_data), 32'd0);
    check("abort_ta_err", 32'(bus.ta_err), 32'd0);
    nd = 0;
    repeat (1400) begin
      @(negedge sysclk);
      if (bus.done) nd++;
    end
    check("abort_no_done", nd, 32'd0);
    run_txn(1'b1, 5'd8, 5'd0, 16'h0, lat);
    check("post_abort_latency", lat, 32'd1281);
    check("post_abort_data", 32'(bus.rd_data), 32'h0040);

    // req held high: done-to-done spacing 1282, two idle cycles.
    bus.req = 1'b1; bus.req_rd = 1'b1;
    bus.phy_addr = 5'd1; bus.reg_addr = 5'd2;
    nd = 0; t = 0; gap = 0; seen = 1'b0;
    while (nd < 3 && t < 5000) begin
      @(negedge sysclk);
      t++;
      if (bus.done) begin
        dt[nd] = t;
        nd++;
      end
      if (nd >= 1 && !seen) begin
        if (bus.busy) seen = 1'b1;
        else gap++;
      end
    end
    bus.req = 1'b0;
    check("b2b_done_count", nd, 32'd3);
    if (nd == 3) begin
      check("b2b_spacing0", dt[1] - dt[0], 32'd1282);
      check("b2b_spacing1", dt[2] - dt[1], 32'd1282);
    end
    check("b2b_idle_gap", gap, 32'd2);
    check("b2b_rd_data", 32'(bus.rd_data), 32'h7e19);
    repeat (2) @(negedge sysclk);
    check("b2b_stop", 32'(bus.busy), 32'd0);

    // A req pulse while busy must be ignored.
    bus.req = 1'b1; bus.req_rd = 1'b1;
    bus.phy_addr = 5'd8; bus.reg_addr = 5'd0;
    @(negedge sysclk);
    bus.req = 1'b0;
    repeat (500) @(negedge sysclk);
    bus.req = 1'b1; bus.req_rd = 1'b0;
    @(negedge sysclk);
    bus.req = 1'b0;
    nd = 0;
    repeat (2000) begin
      @(negedge sysclk);
      if (bus.done) nd++;
    end
    check("busy_req_ignored", nd, 32'd1);
    check("busy_req_data", 32'(bus.rd_data), 32'h0040);
    check("busy_req_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
